// File: rtl/sr_latch_bank_if.sv
// Bus bundle for sr_latch_bank: per-channel set/reset requests, ack handshake and flag summary.
// The bank takes the slave modport; the event source and consumer side takes master.
interface sr_latch_bank_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned IDX_W = 3
);
   logic [WIDTH-1:0] set;
   logic [WIDTH-1:0] reset;
   logic             ack;
   logic [WIDTH-1:0] q;
   logic             any_set;
   logic [IDX_W:0]   count;
   logic             first_valid;
   logic [IDX_W-1:0] first_idx;

   modport master (
      output set, reset, ack,
      input  q, any_set, count, first_valid, first_idx
   );

   modport slave (
      input  set, reset, ack,
      output q, any_set, count, first_valid, first_idx
   );
endinterface

// File: rtl/sr_latch_bank.sv
// Bank of synchronous set/reset flags with a MODE collision policy, summary outputs and ack-clear.
// Optional SR_EDGE_DETECT_EN makes set rising-edge sensitive instead of level sensitive.
module sr_latch_bank #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned IDX_W = 3,
   parameter int unsigned MODE  = 0
) (
   input logic           clk,
   input logic           rst,
   sr_latch_bank_if.slave bus
);
   localparam int unsigned CNT_W    = IDX_W + 1;
   // Out-of-range policies fall back to reset-dominant.
   localparam int unsigned MODE_EFF = (MODE > 2) ? 0 : MODE;

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] set_eff;
   logic [WIDTH-1:0] ack_clr;
   logic [WIDTH-1:0] r_eff;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             valid;

`ifdef SR_EDGE_DETECT_EN
   logic [WIDTH-1:0] set_d;

   always_ff @(posedge clk) begin
      if (rst) set_d <= '0;
      else     set_d <= bus.set;
   end

   assign set_eff = bus.set & ~set_d;
`else
   assign set_eff = bus.set;
`endif

   // Summary over the registered flags: popcount and lowest-index priority encode.
   always_comb begin
      cnt = '0;
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         cnt = cnt + CNT_W'(q_r[i]);
         if (q_r[i]) idx = IDX_W'(i);
      end
   end

   assign valid = |q_r;

   // Next flag state: ack folds into the reset of the channel currently reported.
   always_comb begin
      q_nxt   = q_r;
      ack_clr = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ack_clr[i] = bus.ack & valid & (idx == IDX_W'(i));
      end
      r_eff = bus.reset | ack_clr;
      for (int i = 0; i < WIDTH; i++) begin
         case ({set_eff[i], r_eff[i]})
            2'b10:   q_nxt[i] = 1'b1;
            2'b01:   q_nxt[i] = 1'b0;
            2'b11: begin
               case (MODE_EFF)
                  1:       q_nxt[i] = 1'b1;
                  2:       q_nxt[i] = ~q_r[i];
                  default: q_nxt[i] = 1'b0;
               endcase
            end
            default: q_nxt[i] = q_r[i];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) q_r <= '0;
      else     q_r <= q_nxt;
   end

   assign bus.q           = q_r;
   assign bus.any_set     = valid;
   assign bus.count       = cnt;
   assign bus.first_valid = valid;
   assign bus.first_idx   = idx;
endmodule

// File: tb/tb_sr_latch_bank.sv
// Self-checking bench for sr_latch_bank: directed scenarios pinned by literals, then random traffic
// compared every cycle against a per-channel reference model.
module tb_sr_latch_bank;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned MODE  = 0;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   sr_latch_bank_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

   sr_latch_bank #(.WIDTH(WIDTH), .IDX_W(IDX_W), .MODE(MODE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state.
   logic [WIDTH-1:0] m_q    = '0;
   logic [WIDTH-1:0] m_setd = '0;
   logic [WIDTH-1:0] m_nq;
   logic [WIDTH-1:0] m_eset;
   bit               m_live = 1'b0;
   int               m_lo;
   bit               m_s, m_r;

   function automatic int lowest(input logic [WIDTH-1:0] v);
      for (int i = 0; i < int'(WIDTH); i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Model: each channel follows the set/reset/collision rule; ack acts as reset on the lowest pending flag.
   always @(posedge clk) begin
      if (rst) begin
         m_q    = '0;
         m_setd = '0;
         m_live = 1'b1;
      end else begin
         m_lo   = lowest(m_q);
         m_eset = bus.set;
`ifdef SR_EDGE_DETECT_EN
         m_eset = bus.set & ~m_setd;
`endif
         for (int i = 0; i < int'(WIDTH); i++) begin
            m_s = m_eset[i];
            m_r = bus.reset[i] || (bus.ack && (m_q != 0) && (i == m_lo));
            if (m_s && !m_r)      m_nq[i] = 1'b1;
            else if (!m_s && m_r) m_nq[i] = 1'b0;
            else if (m_s && m_r)  m_nq[i] = (MODE == 1) ? 1'b1 : (MODE == 2) ? !m_q[i] : 1'b0;
            else                  m_nq[i] = m_q[i];
         end
         m_setd = bus.set;
         m_q    = m_nq;
      end
   end

   // Compare every cycle once the model has seen a reset.
   always @(negedge clk) begin
      if (m_live) begin
         chk("q",           32'(bus.q),           32'(m_q));
         chk("any_set",     32'(bus.any_set),     32'(m_q != 0));
         chk("count",       32'(bus.count),       32'($countones(m_q)));
         chk("first_valid", 32'(bus.first_valid), 32'(m_q != 0));
         chk("first_idx",   32'(bus.first_idx),   32'(lowest(m_q)));
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic drive(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] r, input logic a);
      bus.set   = s;
      bus.reset = r;
      bus.ack   = a;
   endtask

   logic [IDX_W-1:0] exp_idx [3];
   logic [WIDTH-1:0] exp_q   [3];
   bit               lvl;
   logic             exp_b;

`ifdef SR_EDGE_DETECT_EN
   initial lvl = 1'b0;
`else
   initial lvl = 1'b1;
`endif

   initial begin
      exp_idx = '{3'd0, 3'd4, 3'd7};
      exp_q   = '{8'h90, 8'h80, 8'h00};
      rst = 1'b1;
      drive(8'hFF, 8'h00, 1'b0);
      @(negedge clk);
      cyc(2);
      chk("rst_q", 32'(bus.q), 32'h00);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_first_valid", 32'(bus.first_valid), 0);
      chk("rst_first_idx", 32'(bus.first_idx), 0);

      rst = 1'b0;
      drive(8'h24, 8'h00, 1'b0);
      cyc();
      chk("set_q", 32'(bus.q), 32'h24);
      chk("set_count", 32'(bus.count), 2);
      chk("set_first_idx", 32'(bus.first_idx), 2);
      chk("set_any", 32'(bus.any_set), 1);
      drive(8'h00, 8'h00, 1'b0);
      cyc();
      chk("hold_q", 32'(bus.q), 32'h24);

      // Collision on channel 3 from a clear flag, twice.
      drive(8'h00, 8'hFF, 1'b0);
      cyc();
      drive(8'h08, 8'h08, 1'b0);
      cyc();
      exp_b = (MODE == 1 || MODE == 2);
      chk("coll1_q3", 32'(bus.q[3]), 32'(exp_b));
      cyc();
      exp_b = lvl ? ((MODE == 1) ? 1'b1 : 1'b0) : 1'b0;
      chk("coll2_q3", 32'(bus.q[3]), 32'(exp_b));

      // Ack drain of 8'h91.
      drive(8'h00, 8'hFF, 1'b0);
      cyc();
      drive(8'h91, 8'h00, 1'b0);
      cyc();
      drive(8'h00, 8'h00, 1'b1);
      for (int k = 0; k < 3; k++) begin
         chk("drain_idx", 32'(bus.first_idx), 32'(exp_idx[k]));
         cyc();
         chk("drain_q", 32'(bus.q), 32'(exp_q[k]));
      end
      chk("drain_fv", 32'(bus.first_valid), 0);
      cyc();
      chk("drain_extra_ack", 32'(bus.q), 32'h00);

      // Ack against a held set on channel 0.
      drive(8'h01, 8'h00, 1'b0);
      cyc();
      chk("held_set_q0", 32'(bus.q[0]), 1);
      bus.ack = 1'b1;
      cyc();
      exp_b = lvl ? ((MODE == 1) ? 1'b1 : 1'b0) : 1'b0;
      chk("held_ack_q0", 32'(bus.q[0]), 32'(exp_b));
      bus.ack = 1'b0;
      cyc();
      chk("held_after_q0", 32'(bus.q[0]), 32'(lvl));
      bus.set = 8'h00;
      cyc();
      bus.set = 8'h01;
      cyc();
      chk("rearm_q0", 32'(bus.q[0]), 1);

      // Reset coinciding with ack while all flags set.
      drive(8'h00, 8'h00, 1'b0);
      cyc();
      bus.set = 8'hFF;
      cyc();
      chk("full_q", 32'(bus.q), 32'hFF);
      chk("full_count", 32'(bus.count), 8);
      drive(8'h00, 8'h00, 1'b1);
      rst = 1'b1;
      cyc();
      chk("midrst_q", 32'(bus.q), 32'h00);
      chk("midrst_count", 32'(bus.count), 0);
      rst = 1'b0;
      bus.ack = 1'b0;

      // Random traffic, checked each cycle by the compare process.
      for (int n = 0; n < 3000; n++) begin
         drive(WIDTH'($urandom & $urandom), WIDTH'($urandom & $urandom & $urandom),
               1'($urandom_range(0, 2) == 0));
         rst = ($urandom_range(0, 99) == 0);
         cyc();
      end
      rst = 1'b0;
      drive(8'h00, 8'h00, 1'b0);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sr_latch_bank.md
Name: sr_latch_bank

Overview:
- Clocked, parametrised bank of WIDTH set/reset flag channels.
- Successor to the single asynchronous cross-coupled SR latch: each channel is a synchronous flag whose set/reset collision policy is selected by MODE.
- Adds summary logic over the flags: any-set, population count, and a lowest-index priority encoder with an acknowledge handshake that clears the reported flag.
- Sits between gate-level event sources and a consumer that services pending events one at a time.

Parameters:
- WIDTH, 8, number of flag channels (1..32).
- IDX_W, 3, index width; must satisfy 2**IDX_W >= WIDTH.
- MODE, 0, collision policy when set and reset are both active on a channel: 0 = reset-dominant, 1 = set-dominant, 2 = toggle (JK behaviour).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- set  input  WIDTH  per-channel set request.
- reset  input  WIDTH  per-channel reset request.
- ack  input  1  consumer acknowledges the channel currently on first_idx.
- q  output  WIDTH  registered flag state.
- any_set  output  1  OR-reduction of q.
- count  output  IDX_W+1  number of ones in q.
- first_valid  output  1  high when at least one flag is set.
- first_idx  output  IDX_W  lowest index i with q[i]=1; 0 when first_valid=0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst is high at a clock edge, q becomes 0 and all other inputs are ignored. Consequently any_set=0, count=0, first_valid=0 and first_idx=0 after that edge.
- Reset mid-operation: a pending ack is discarded. With SR_EDGE_DETECT_EN, the set history register is also cleared.
- Effective reset per channel: r_eff[i] = reset[i] | (ack & first_valid & (first_idx==i)). ack while first_valid=0 has no effect.
- Next-state per channel at each edge (rst low):
  - set=0, r_eff=0: hold.
  - set=1, r_eff=0: q becomes 1.
  - set=0, r_eff=1: q becomes 0.
  - set=1, r_eff=1: MODE0 gives 0; MODE1 gives 1; MODE2 inverts q.
- Latency: the q change is visible after the edge that samples the request (1 cycle).
- Derived outputs: any_set, count, first_valid and first_idx are combinational from registered q, so they carry no extra latency relative to q.
- Width rules: count is zero-extended popcount and reaches WIDTH with all flags set, with no overflow. first_idx uses a strict lowest-index priority. Channels are independent except through ack.
- Ack handshake:
  - The consumer samples first_idx and pulses ack for one cycle.
  - The next edge clears that flag, and first_idx moves to the next pending index in the same cycle q updates.
  - If ack is held high, one flag clears per cycle, lowest first.
  - If set on the acked channel is active in the same cycle, the MODE collision rule applies; MODE1 therefore keeps the flag set.
- Boundary conditions:
  - All flags set: count = WIDTH.
  - All flags clear: first_idx = 0 and first_valid = 0.
  - A channel index >= WIDTH never appears on first_idx.
  - Illegal MODE (>2) behaves as MODE0.

Optional Feature:
- Macro: SR_EDGE_DETECT_EN.
- Defined: set is rising-edge sensitive. The bank registers set_d (reset to 0) and uses set[i] & ~set_d[i] as the effective set. A set held high therefore does not re-assert the flag after ack or reset clears it.
- Undefined: set is level-sensitive as described under Behaviour. A held set re-asserts the flag every cycle, and an ack against a held set obeys MODE.

Test Plan:
- Reset: rst=1 for 2 cycles with set=8'hFF -> q=8'h00, count=0, first_valid=0, first_idx=0.
- Set and summary: set=8'b0010_0100 for 1 cycle -> next cycle q=8'h24, count=2, first_idx=2, any_set=1; q holds 8'h24 after set returns to 0.
- Collision per MODE: q[3]=0, set[3]=reset[3]=1 for 1 cycle -> MODE0 gives q[3]=0; MODE1 gives q[3]=1; MODE2 gives q[3]=1, and a second identical cycle gives q[3]=0.
- Ack drain: q=8'h91, ack held 3 cycles -> first_idx sequence 0,4,7; q sequence 8'h90, 8'h80, 8'h00; then first_valid=0, and a further ack has no effect.
- Ack vs held set: MODE0, set[0] held high, q[0]=1, ack pulsed -> level mode gives q[0]=0 for one cycle, then 1 again; with SR_EDGE_DETECT_EN, q[0] stays 0 until set[0] falls and rises.
- Reset mid-drain: q=8'hFF, ack=1 and rst=1 on the same edge -> q=8'h00 and count=0, with no partial clear observed.
